// File: rtl/i2c_slave_rx.sv
// Write-only I2C target receiver: synchronises SCL/SDA, tracks START/STOP, matches a 7-bit
// address, ACKs via open-drain enable and hands received bytes out on a valid/ready port.
`timescale 1ns/1ps
module i2c_slave_rx #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  input  logic       i2c_sda,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       addr_hit,
  output logic       stop_seen,
  output logic       rx_overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StData,
    StDataAck,
    StIgnore
  } state_e;

  logic       r_scl_s1, r_scl_s2, r_scl_h;
  logic       r_sda_s1, r_sda_s2, r_sda_h;
  state_e     r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_ack;
  logic       r_ack_phase;
  logic       r_sda_oe;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_addr_hit;
  logic       r_stop_seen;
  logic       r_rx_overrun;
  logic       r_busy;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_take;
  logic [7:0] w_byte;

  // Synchronisers reset to 1 so an idle bus produces no spurious edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_h  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_h  <= 1'b1;
    end else begin
      r_scl_s1 <= i2c_scl;
      r_scl_s2 <= r_scl_s1;
      r_scl_h  <= r_scl_s2;
      r_sda_s1 <= i2c_sda;
      r_sda_s2 <= r_sda_s1;
      r_sda_h  <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_h;
  assign w_scl_fall = ~r_scl_s2 & r_scl_h;
  assign w_start    = r_scl_s2 & r_scl_h & r_sda_h & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_h & ~r_sda_h & r_sda_s2;
  assign w_byte     = {r_shift[6:0], r_sda_s2};
  assign w_take     = r_rx_valid & rx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'h00;
      r_ack        <= 1'b0;
      r_ack_phase  <= 1'b0;
      r_sda_oe     <= 1'b0;
      r_rx_data    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_addr_hit   <= 1'b0;
      r_stop_seen  <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_stop_seen  <= 1'b0;
      r_rx_overrun <= 1'b0;
      if (w_take) r_rx_valid <= 1'b0;

      if (w_start) begin
        r_state    <= StAddr;
        r_bit_cnt  <= 3'd0;
        r_sda_oe   <= 1'b0;
        r_addr_hit <= 1'b0;
        r_busy     <= 1'b1;
      end else if (w_stop) begin
        r_state     <= StIdle;
        r_sda_oe    <= 1'b0;
        r_addr_hit  <= 1'b0;
        r_busy      <= 1'b0;
        r_stop_seen <= 1'b1;
      end else begin
        unique case (r_state)
          StIdle, StIgnore: ;
          StAddr: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_ack       <= (w_byte[7:1] == ADDR) && !w_byte[0];
                r_ack_phase <= 1'b0;
                r_state     <= StAddrAck;
              end
            end
          end
          StData: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_ack_phase <= 1'b0;
                r_state     <= StDataAck;
                // A byte consumed on this same edge frees the slot for the new one.
                if (!r_rx_valid || rx_ready) begin
                  r_rx_data  <= w_byte;
                  r_rx_valid <= 1'b1;
                  r_ack      <= 1'b1;
                end else begin
                  r_rx_overrun <= 1'b1;
                  r_ack        <= 1'b0;
                end
              end
            end
          end
          StAddrAck: begin
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_ack_phase <= 1'b1;
                r_sda_oe    <= r_ack;
                r_addr_hit  <= r_ack;
              end else begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 3'd0;
                r_state   <= r_ack ? StData : StIgnore;
              end
            end
          end
          StDataAck: begin
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_ack_phase <= 1'b1;
                r_sda_oe    <= r_ack;
              end else begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 3'd0;
                r_state   <= StData;
              end
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign sda_oe     = r_sda_oe;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign addr_hit   = r_addr_hit;
  assign stop_seen  = r_stop_seen;
  assign rx_overrun = r_rx_overrun;
  assign busy       = r_busy;

endmodule
